// File: rtl/sad_search_sequencer.sv
// sad_search_sequencer: full-search motion-estimation sequencer, one window request per origin, tracks minimum SAD.
module sad_search_sequencer #(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int WIN = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Abort,
  output logic        ReqValid,
  input  logic        ReqReady,
  output logic [31:0] WinAddr,
  input  logic        SadValid,
  input  logic [31:0] SadValue,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] BestSad,
  output logic [15:0] BestRow,
  output logic [15:0] BestCol
);
  localparam logic [15:0] MAX_ROW = 16'(FRAME_H - WIN);
  localparam logic [15:0] MAX_COL = 16'(FRAME_W - WIN);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} stateT;
  stateT state, nextState;
  logic [15:0] row, col;
  logic [31:0] bestSad;
  logic [15:0] bestRow, bestCol;
  logic colEnd, lastPos, startSearch, take;
  assign colEnd = col == MAX_COL;
  assign lastPos = colEnd && row == MAX_ROW;
  assign startSearch = state == IDLE && Start && !Abort;
  // A result only counts in WAIT; results seen during the handshake cycle belong to no request.
  assign take = state == WAIT && SadValid && !Abort;
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = Start ? ISSUE : IDLE;
      ISSUE:   nextState = ReqReady ? WAIT : ISSUE;
      WAIT:    nextState = SadValid ? (lastPos ? DONE : ISSUE) : WAIT;
      default: nextState = IDLE;
    endcase
    if (Abort) nextState = IDLE;
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      bestSad <= '1;
      bestRow <= '0;
      bestCol <= '0;
    end else begin
      state <= nextState;
      if (startSearch) begin
        row <= '0;
        col <= '0;
        bestSad <= '1;
        bestRow <= '0;
        bestCol <= '0;
      end
      if (take) begin
        if (SadValue < bestSad) begin
          bestSad <= SadValue;
          bestRow <= row;
          bestCol <= col;
        end
        if (!lastPos) begin
          col <= colEnd ? '0 : col + 16'd1;
          row <= colEnd ? row + 16'd1 : row;
        end
      end
    end
  end
  assign ReqValid = state == ISSUE;
  assign Busy = state != IDLE;
  assign Done = state == DONE;
  assign WinAddr = ({16'd0, row} * 32'(FRAME_W) + {16'd0, col}) << 2;
  assign BestSad = bestSad;
  assign BestRow = bestRow;
  assign BestCol = bestCol;
endmodule
